// File: rtl/fp_pkg.sv
// Shared helpers for the floating-point datapath: field extract/pack,
// classification and the constants the adder pipeline relies on.
package fp_pkg;

  // Container width for the width-generic helpers below (covers up to binary64).
  localparam int FP_MAX_W = 64;

  // Guard, round and sticky bits carried below the aligned significand.
  localparam int GRS_W = 3;

  // Canonical NaN returned for every invalid operation: the all-ones word.
  localparam logic [FP_MAX_W-1:0] FP_CANON_NAN = '1;

  function automatic logic [FP_MAX_W-1:0] fp_mask(input int n);
    return (FP_MAX_W'(1) << n) - FP_MAX_W'(1);
  endfunction

  function automatic logic fp_sign(input logic [FP_MAX_W-1:0] w, input int ew, input int mw);
    return 1'(w >> (ew + mw));
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_exp(input logic [FP_MAX_W-1:0] w, input int ew,
                                                 input int mw);
    return (w >> mw) & fp_mask(ew);
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_man(input logic [FP_MAX_W-1:0] w, input int mw);
    return w & fp_mask(mw);
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_pack(input logic s, input logic [FP_MAX_W-1:0] e,
                                                  input logic [FP_MAX_W-1:0] m, input int ew,
                                                  input int mw);
    return (FP_MAX_W'(s) << (ew + mw)) | ((e & fp_mask(ew)) << mw) | (m & fp_mask(mw));
  endfunction

  function automatic logic fp_is_nan(input logic [FP_MAX_W-1:0] w, input int ew, input int mw);
    return (fp_exp(w, ew, mw) == fp_mask(ew)) && (fp_man(w, mw) != '0);
  endfunction

  function automatic logic fp_is_inf(input logic [FP_MAX_W-1:0] w, input int ew, input int mw);
    return (fp_exp(w, ew, mw) == fp_mask(ew)) && (fp_man(w, mw) == '0);
  endfunction

  // Zero exponent counts as zero: denormals are flushed to signed zero.
  function automatic logic fp_is_zero(input logic [FP_MAX_W-1:0] w, input int ew, input int mw);
    return fp_exp(w, ew, mw) == '0;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter int WIDTH = 28
) (
  input  logic [WIDTH-1:0]           value,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int CW = $clog2(WIDTH + 1);

  // Scan upward so the most significant set bit has the final say.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage floating-point adder/subtractor with valid/ready handshake,
// round-to-nearest-even, flush-to-zero and IEEE special-value handling.
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [EW+MW:0] a,
  input  logic [EW+MW:0] b,
  input  logic           sub,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [EW+MW:0] z
);

  localparam int W   = EW + MW + 1;
  localparam int FW  = MW + 1 + GRS_W;
  localparam int SW  = FW + 1;
  localparam int LZW = $clog2(SW + 1);
  localparam int EXW = EW + 2;

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic [FP_MAX_W-1:0] a_ext, b_ext;
  assign a_ext = FP_MAX_W'(a);
  assign b_ext = FP_MAX_W'(b);

  // Stage 1 combinational: classify, resolve specials, order by magnitude, align.
  logic          sa, sb, sx, sy, a_big, special1;
  logic [EW-1:0] ea, eb, ex, ey, ediff;
  logic [MW-1:0] ma, mb, mx, my;
  logic [FW-1:0] my_ext, my_sh, mx_al, my_al;
  logic [W-1:0]  word1;
  always_comb begin
    sa = fp_sign(a_ext, EW, MW);
    sb = fp_sign(b_ext, EW, MW) ^ sub;
    ea = EW'(fp_exp(a_ext, EW, MW));
    eb = EW'(fp_exp(b_ext, EW, MW));
    ma = MW'(fp_man(a_ext, MW));
    mb = MW'(fp_man(b_ext, MW));
    special1 = 1'b1;
    word1    = '0;
    if (fp_is_nan(a_ext, EW, MW) || fp_is_nan(b_ext, EW, MW) ||
        (fp_is_inf(a_ext, EW, MW) && fp_is_inf(b_ext, EW, MW) && (sa != sb)))
      word1 = W'(FP_CANON_NAN);
    else if (fp_is_inf(a_ext, EW, MW))
      word1 = W'(fp_pack(sa, fp_mask(EW), '0, EW, MW));
    else if (fp_is_inf(b_ext, EW, MW))
      word1 = W'(fp_pack(sb, fp_mask(EW), '0, EW, MW));
    else if (fp_is_zero(a_ext, EW, MW) && fp_is_zero(b_ext, EW, MW))
      word1 = W'(fp_pack(sa & sb, '0, '0, EW, MW));
    else if (fp_is_zero(a_ext, EW, MW))
      word1 = W'(fp_pack(sb, FP_MAX_W'(eb), FP_MAX_W'(mb), EW, MW));
    else if (fp_is_zero(b_ext, EW, MW))
      word1 = W'(fp_pack(sa, FP_MAX_W'(ea), FP_MAX_W'(ma), EW, MW));
    else
      special1 = 1'b0;

    a_big  = {ea, ma} >= {eb, mb};
    sx     = a_big ? sa : sb;
    sy     = a_big ? sb : sa;
    ex     = a_big ? ea : eb;
    ey     = a_big ? eb : ea;
    mx     = a_big ? ma : mb;
    my     = a_big ? mb : ma;
    ediff  = ex - ey;
    mx_al  = {1'b1, mx, {GRS_W{1'b0}}};
    my_ext = {1'b1, my, {GRS_W{1'b0}}};
    my_sh  = my_ext >> ediff;
    if (32'(ediff) >= 32'(MW + GRS_W))
      my_al = FW'(1);
    else
      my_al = {my_sh[FW-1:1], my_sh[0] | (|(my_ext & ~({FW{1'b1}} << ediff)))};
  end

  logic          s1_valid, s1_special, s1_sign, s1_sub;
  logic [W-1:0]  s1_word;
  logic [EW-1:0] s1_exp;
  logic [FW-1:0] s1_mx, s1_my;

  // Stage 1 register: capture aligned operands whenever the pipe is moving.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0; s1_special <= 1'b0; s1_sign <= 1'b0; s1_sub <= 1'b0;
      s1_word  <= '0;   s1_exp     <= '0;   s1_mx   <= '0;   s1_my  <= '0;
    end else if (!stall) begin
      s1_valid   <= in_valid;
      s1_special <= special1;
      s1_word    <= word1;
      s1_sign    <= sx;
      s1_sub     <= sx ^ sy;
      s1_exp     <= ex;
      s1_mx      <= mx_al;
      s1_my      <= my_al;
    end
  end

  // Stage 2: magnitude add or subtract; X is never smaller than Y.
  logic [SW-1:0]  sum2;
  logic [LZW-1:0] lzc2;
  assign sum2 = s1_sub ? ({1'b0, s1_mx} - {1'b0, s1_my}) : ({1'b0, s1_mx} + {1'b0, s1_my});

  fp_lzc #(.WIDTH(SW)) u_lzc (
    .value(sum2),
    .count(lzc2)
  );

  logic           s2_valid, s2_special, s2_sign;
  logic [W-1:0]   s2_word;
  logic [EW-1:0]  s2_exp;
  logic [SW-1:0]  s2_sum;
  logic [LZW-1:0] s2_lzc;

  // Stage 2 register: raw sum plus its leading-zero count.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0; s2_special <= 1'b0; s2_sign <= 1'b0;
      s2_word  <= '0;   s2_exp     <= '0;   s2_sum  <= '0; s2_lzc <= '0;
    end else if (!stall) begin
      s2_valid   <= s1_valid;
      s2_special <= s1_special;
      s2_word    <= s1_word;
      s2_sign    <= s1_sign;
      s2_exp     <= s1_exp;
      s2_sum     <= sum2;
      s2_lzc     <= lzc2;
    end
  end

  // Stage 3 combinational: normalise (lzc of 1 means already normal), round, pack.
  logic           carry, guard, rnd, sticky, round_up;
  logic [LZW-1:0] sh;
  logic [SW-2:0]  shifted;
  logic [MW:0]    mant;
  logic [MW+1:0]  mant_r;
  logic [MW-1:0]  frac;
  logic [EXW-1:0] e_pre, e_fin;
  logic [W-1:0]   z_next;
  always_comb begin
    carry   = s2_sum[SW-1];
    sh      = s2_lzc - LZW'(1);
    shifted = (SW-1)'(s2_sum << sh);
    if (carry) begin
      mant   = s2_sum[SW-1:4];
      guard  = s2_sum[3];
      rnd    = s2_sum[2];
      sticky = s2_sum[1] | s2_sum[0];
      e_pre  = EXW'(s2_exp) + EXW'(1);
    end else begin
      mant   = shifted[SW-2:3];
      guard  = shifted[2];
      rnd    = shifted[1];
      sticky = shifted[0];
      e_pre  = EXW'(s2_exp) - EXW'(sh);
    end
    round_up = guard & (rnd | sticky | mant[0]);
    mant_r   = {1'b0, mant} + (MW+2)'(round_up);
    if (mant_r[MW+1]) begin
      frac  = mant_r[MW:1];
      e_fin = e_pre + EXW'(1);
    end else begin
      frac  = mant_r[MW-1:0];
      e_fin = e_pre;
    end

    if (s2_special)
      z_next = s2_word;
    else if (s2_sum == '0)
      z_next = '0;
    else if (!e_fin[EXW-1] && (e_fin >= EXW'((1 << EW) - 1)))
      z_next = {s2_sign, {EW{1'b1}}, {MW{1'b0}}};
    else if (e_fin[EXW-1] || (e_fin == '0))
      z_next = {s2_sign, {(EW+MW){1'b0}}};
    else
      z_next = {s2_sign, e_fin[EW-1:0], frac};
  end

  // Output register: holds result and valid steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      z         <= '0;
    end else if (!stall) begin
      out_valid <= s2_valid;
      z         <= z_next;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Self-checking bench for fp_add_pipe in single precision: directed vector
// table plus back-pressure and mid-stream reset sequences.
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] a, b, z;

  fp_add_pipe #(.EW(8), .MW(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .z(z)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] expected;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Present one op with out_ready high; report the result and the number of
  // clock edges from acceptance (inclusive) until out_valid is seen.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                               output logic [31:0] res, output int lat);
    in_valid = 1'b1; a = av; b = bv; sub = sv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    res = z;
  endtask

  // Top-level test sequence.
  initial begin
    logic [31:0] res;
    int          lat, sent, got, stall_cyc;
    bit          first_seen, checked_hold, stale;
    logic [31:0] bp_b   [6];
    logic [31:0] bp_exp [6];

    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000};
    vecs[2]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002};
    vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000};
    vecs[4]  = '{32'h3F800000, 32'hB3800000, 1'b0, 32'h3F7FFFFF};
    vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000};
    vecs[6]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'hFFFFFFFF};
    vecs[7]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'hFFFFFFFF};
    vecs[8]  = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000};
    vecs[9]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000};
    vecs[10] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
    vecs[11] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000};
    vecs[12] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001};
    vecs[13] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000};
    vecs[14] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000};
    vecs[15] = '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000};
    vecs[16] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000};
    vecs[17] = '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000};
    vecs[18] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'hFFFFFFFF};
    vecs[19] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000};

    bp_b   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    bp_exp = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};

    // Reset state.
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_z", z, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, res, lat);
      checkOutput($sformatf("vec%0d_z", i), res, vecs[i].expected);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    end
    @(posedge clk); #1;

    // Back-pressure: six ops streamed, consumer stalls once the first result shows.
    sent = 0; got = 0; stall_cyc = 0; first_seen = 0; checked_hold = 0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      if (out_valid) first_seen = 1;
      out_ready = !(first_seen && stall_cyc < 5);
      in_valid  = (sent < 6);
      a   = 32'h3F800000;
      b   = bp_b[(sent < 6) ? sent : 5];
      sub = 1'b0;
      #1;
      if (out_valid && !out_ready) begin
        stall_cyc++;
        if (!checked_hold) begin
          checked_hold = 1;
          checkOutput("bp_ops_held", 32'(sent), 32'd3);
        end
        checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
        checkOutput("bp_z_hold", z, bp_exp[got]);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        checkOutput($sformatf("bp_result%0d", got), z, bp_exp[got]);
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checkOutput("bp_results_count", 32'(got), 32'd6);
    checkOutput("bp_ops_sent", 32'(sent), 32'd6);
    checkOutput("bp_stall_cycles", 32'(stall_cyc), 32'd5);
    stale = 0;
    repeat (4) begin
      if (out_valid) stale = 1;
      @(posedge clk); #1;
    end
    checkOutput("bp_no_duplicate", 32'(stale), 32'd0);

    // Reset mid-stream with three ops in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'h3F800000; b = bp_b[i]; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checkOutput("rst_pipe_full", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_z", z, 32'h0);
    stale = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1;
    end
    checkOutput("rst_no_stale", 32'(stale), 32'd0);
    applyStimulus(32'h40400000, 32'h3F800000, 1'b1, res, lat);
    checkOutput("rst_after_z", res, 32'h40000000);
    checkOutput("rst_after_latency", 32'(lat), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
